// File: rtl/avg_capture.sv
// avg_capture: arm/trigger capture of decimated averages into a 2**A RAM, then popped one at a time.
// Optional 8-bit tick prescaler with a `decim` port when AVG_CAPTURE_DECIM_EN is defined.
module avg_capture #(
  parameter int R = 14,
  parameter int A = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [R-1:0] in_data,
  input  logic                in_tick,
  input  logic                arm,
  input  logic                trig,
`ifdef AVG_CAPTURE_DECIM_EN
  input  logic [7:0]          decim,
`endif
  input  logic                rd_en,
  output logic signed [R-1:0] rd_data,
  output logic                rd_valid,
  output logic [A:0]          count,
  output logic [1:0]          state,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [A:0] FULL = {1'b1, {A{1'b0}}};

  state_t               st, st_nx;
  logic                 clr, wr_en, rd_go, tick_take;
  logic [A-1:0]         wptr, rptr;
  logic signed [R-1:0]  mem [2**A];

`ifdef AVG_CAPTURE_DECIM_EN
  // Prescaler phase 0 marks the tick to keep; it only advances on FILL ticks.
  logic [7:0] pre;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre <= 8'd0;
    end else if (st == S_FILL && in_tick) begin
      pre <= (pre >= decim) ? 8'd0 : pre + 8'd1;
    end
  end

  assign tick_take = (pre == 8'd0);
`else
  assign tick_take = 1'b1;
`endif

  always_comb begin
    st_nx = st;
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_go = 1'b0;
    if (arm) begin
      st_nx = S_ARMED;
      clr   = 1'b1;
    end else begin
      case (st)
        S_IDLE:  st_nx = S_IDLE;
        S_ARMED: if (trig) st_nx = S_FILL;
        S_FILL: begin
          if (in_tick && tick_take && count != FULL) begin
            wr_en = 1'b1;
            if (count == FULL - 1'b1) st_nx = S_DONE;
          end
        end
        S_DONE:  if (rd_en && count != '0) rd_go = 1'b1;
        default: st_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      st       <= st_nx;
      done     <= (st_nx == S_DONE);
      rd_valid <= rd_go;
      if (clr) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else if (wr_en) begin
        wptr  <= wptr + 1'b1;
        count <= count + 1'b1;
      end else if (rd_go) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
        count   <= count - 1'b1;
      end
    end
  end

  // Write port kept free of reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= in_data;
  end

  assign state = st;

endmodule
